// File: rtl/scaler_tick_requester_pkg.sv
// Shared constants for the scaler tick requester: channel indices, arbiter states
// and the lowest-pending-channel helper.
package agc_tick_pkg;

  localparam int NUM_TICK_CH = 5;

  localparam logic [2:0] CH_TIME1 = 3'd0;
  localparam logic [2:0] CH_TIME3 = 3'd1;
  localparam logic [2:0] CH_TIME4 = 3'd2;
  localparam logic [2:0] CH_TIME5 = 3'd3;
  localparam logic [2:0] CH_TIME6 = 3'd4;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_REQ  = 1'b1
  } arb_state_e;

  // Fixed priority: the lowest channel index wins.
  function automatic logic [2:0] lowest_pending(input logic [NUM_TICK_CH-1:0] p);
    lowest_pending = 3'd0;
    for (int i = NUM_TICK_CH - 1; i >= 0; i--) begin
      if (p[i]) lowest_pending = 3'(i);
    end
  endfunction

endpackage

// File: rtl/scaler_tick_requester_if.sv
// PINC request/acknowledge handshake between the tick requester and the
// counter-increment sequencer.
interface scaler_tick_requester_if;
  logic       pinc_req;
  logic [2:0] pinc_ch;
  logic       pinc_ack;

  modport master (output pinc_req, output pinc_ch, input pinc_ack);
  modport slave  (input pinc_req, input pinc_ch, output pinc_ack);
endinterface

// File: rtl/scaler_tick_requester_edge_chan.sv
// One tick channel: edge detector on a scaler phase, pending request bit and
// sticky overrun flag.
module tick_edge_chan #(
  parameter bit RISE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  input  logic arm,
  input  logic edge_en,
  input  logic ack_clr,
  input  logic ovr_clr,
  output logic pending,
  output logic ovr_flag,
  output logic ovr_event
);

  logic prev;
  logic edge_det;
  logic hit;

  assign edge_det  = arm & (RISE ? (sig & ~prev) : (~sig & prev));
  assign hit       = edge_det & edge_en;
  // An edge landing in the ack cycle re-arms the request instead of overrunning.
  assign ovr_event = hit & pending & ~ack_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= 1'b0;
      pending  <= 1'b0;
      ovr_flag <= 1'b0;
    end else begin
      prev <= sig;
      if (hit)          pending <= 1'b1;
      else if (ack_clr) pending <= 1'b0;
      if (ovr_clr)        ovr_flag <= 1'b0;
      else if (ovr_event) ovr_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/scaler_tick_requester.sv
// Turns scaler phase edges into one-at-a-time PINC requests for TIME1/3/4/5/6.
// Build option: define TICK_TIME6_EN to enable the TIME6 channel (f06b gated by t6_en).
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | no request outstanding; picks lowest pending ch
// ST_REQ   | pinc_req high, pinc_ch held until pinc_ack
module scaler_tick_requester
  import agc_tick_pkg::*;
#(
  parameter int OVR_CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    f10a,
  input  logic                    f10b,
  input  logic                    f06b,
  input  logic                    tick_en,
  input  logic                    t6_en,
  input  logic                    ovr_clr,
  scaler_tick_requester_if.master pinc,
  output logic [NUM_TICK_CH-1:0]  ovr_flags,
  output logic [OVR_CNT_W-1:0]    ovr_count
);

  localparam logic [0:0] ST_IDLE = ARB_IDLE;
  localparam logic [0:0] ST_REQ  = ARB_REQ;
  localparam logic [OVR_CNT_W-1:0] OVR_MAX = '1;

  logic [0:0]             state;
  logic                   prime;
  logic                   req_q;
  logic [2:0]             ch_q;
  logic [NUM_TICK_CH-1:0] pending;
  logic [NUM_TICK_CH-1:0] ovr_ev;
  logic [NUM_TICK_CH-1:0] ack_clr;
  logic                   grant_ack;

  assign pinc.pinc_req = req_q;
  assign pinc.pinc_ch  = ch_q;
  assign grant_ack     = (state == ST_REQ) & pinc.pinc_ack;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_TICK_CH; i++) begin
      ack_clr[i] = grant_ack & (ch_q == 3'(i));
    end
  end

  // First clock out of reset only loads prev, so static levels never look like edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prime <= 1'b1;
    else        prime <= 1'b0;
  end

  tick_edge_chan #(.RISE(1'b1)) u_time1 (
    .clk(clk), .rst_n(rst_n), .sig(f10b), .arm(~prime), .edge_en(tick_en),
    .ack_clr(ack_clr[CH_TIME1]), .ovr_clr(ovr_clr), .pending(pending[CH_TIME1]),
    .ovr_flag(ovr_flags[CH_TIME1]), .ovr_event(ovr_ev[CH_TIME1])
  );

  tick_edge_chan #(.RISE(1'b1)) u_time3 (
    .clk(clk), .rst_n(rst_n), .sig(f10a), .arm(~prime), .edge_en(tick_en),
    .ack_clr(ack_clr[CH_TIME3]), .ovr_clr(ovr_clr), .pending(pending[CH_TIME3]),
    .ovr_flag(ovr_flags[CH_TIME3]), .ovr_event(ovr_ev[CH_TIME3])
  );

  tick_edge_chan #(.RISE(1'b0)) u_time4 (
    .clk(clk), .rst_n(rst_n), .sig(f10a), .arm(~prime), .edge_en(tick_en),
    .ack_clr(ack_clr[CH_TIME4]), .ovr_clr(ovr_clr), .pending(pending[CH_TIME4]),
    .ovr_flag(ovr_flags[CH_TIME4]), .ovr_event(ovr_ev[CH_TIME4])
  );

  tick_edge_chan #(.RISE(1'b0)) u_time5 (
    .clk(clk), .rst_n(rst_n), .sig(f10b), .arm(~prime), .edge_en(tick_en),
    .ack_clr(ack_clr[CH_TIME5]), .ovr_clr(ovr_clr), .pending(pending[CH_TIME5]),
    .ovr_flag(ovr_flags[CH_TIME5]), .ovr_event(ovr_ev[CH_TIME5])
  );

`ifdef TICK_TIME6_EN
  tick_edge_chan #(.RISE(1'b1)) u_time6 (
    .clk(clk), .rst_n(rst_n), .sig(f06b), .arm(~prime), .edge_en(tick_en & t6_en),
    .ack_clr(ack_clr[CH_TIME6]), .ovr_clr(ovr_clr), .pending(pending[CH_TIME6]),
    .ovr_flag(ovr_flags[CH_TIME6]), .ovr_event(ovr_ev[CH_TIME6])
  );
`else
  logic unused_time6;
  assign unused_time6        = t6_en ^ f06b ^ ack_clr[CH_TIME6];
  assign pending[CH_TIME6]   = 1'b0;
  assign ovr_flags[CH_TIME6] = 1'b0;
  assign ovr_ev[CH_TIME6]    = 1'b0;
`endif

  // Simultaneous overruns on several channels count as a single event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_count <= '0;
    end else if (ovr_clr) begin
      ovr_count <= '0;
    end else if ((|ovr_ev) && (ovr_count != OVR_MAX)) begin
      ovr_count <= ovr_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      req_q <= 1'b0;
      ch_q  <= CH_TIME1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pending) begin
            ch_q  <= lowest_pending(pending);
            req_q <= 1'b1;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (pinc.pinc_ack) begin
            req_q <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scaler_tick_requester.sv
// Randomized plus directed bench for scaler_tick_requester against a cycle-level
// reference model of the request/overrun rules.
module tb_scaler_tick_requester;

  localparam int W      = 4;
  localparam int CNTMAX = (1 << W) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       f10a = 1'b0, f10b = 1'b0, f06b = 1'b0;
  logic       tick_en = 1'b1, t6_en = 1'b0, ovr_clr = 1'b0;
  logic [4:0] ovr_flags;
  logic [W-1:0] ovr_count;

  scaler_tick_requester_if pinc_bus ();

  scaler_tick_requester #(.OVR_CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .f10a(f10a), .f10b(f10b), .f06b(f06b),
    .tick_en(tick_en), .t6_en(t6_en), .ovr_clr(ovr_clr), .pinc(pinc_bus),
    .ovr_flags(ovr_flags), .ovr_count(ovr_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  int m_pend[5];
  bit m_prime, pa, pb, p6, m_req;
  int m_flags, m_cnt, m_ch;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_pend[i] = 0;
    m_prime = 1; pa = 0; pb = 0; p6 = 0; m_req = 0;
    m_flags = 0; m_cnt = 0; m_ch = 0;
  endtask

  task automatic model_step();
    bit e[5];
    int new_p[5];
    int ack_ch, ovr_bits, lo;
    e[0] = !m_prime && f10b && !pb;
    e[1] = !m_prime && f10a && !pa;
    e[2] = !m_prime && !f10a && pa;
    e[3] = !m_prime && !f10b && pb;
`ifdef TICK_TIME6_EN
    e[4] = !m_prime && f06b && !p6 && t6_en;
`else
    e[4] = 0;
`endif
    ack_ch   = (m_req && pinc_bus.pinc_ack) ? m_ch : -1;
    ovr_bits = 0;
    for (int i = 0; i < 5; i++) begin
      if (e[i] && tick_en) begin
        if (m_pend[i] != 0 && i != ack_ch) ovr_bits |= (1 << i);
        new_p[i] = 1;
      end else begin
        new_p[i] = (i == ack_ch) ? 0 : m_pend[i];
      end
    end
    if (ovr_clr) begin
      m_flags = 0; m_cnt = 0;
    end else begin
      m_flags |= ovr_bits;
      if (ovr_bits != 0 && m_cnt < CNTMAX) m_cnt++;
    end
    if (m_req) begin
      if (pinc_bus.pinc_ack) m_req = 0;
    end else begin
      lo = -1;
      for (int i = 4; i >= 0; i--) if (m_pend[i] != 0) lo = i;
      if (lo >= 0) begin m_req = 1; m_ch = lo; end
    end
    for (int i = 0; i < 5; i++) m_pend[i] = new_p[i];
    pa = f10a; pb = f10b; p6 = f06b; m_prime = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("req",   int'(pinc_bus.pinc_req), int'(m_req));
    check("ch",    int'(pinc_bus.pinc_ch),  m_ch);
    check("flags", int'(ovr_flags),         m_flags);
    check("count", int'(ovr_count),         m_cnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_req",   int'(pinc_bus.pinc_req), 0);
    check("rst_ch",    int'(pinc_bus.pinc_ch),  0);
    check("rst_flags", int'(ovr_flags),         0);
    check("rst_count", int'(ovr_count),         0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    pinc_bus.pinc_ack = 1'b0;
    f10a = 1'b1;
    model_reset();
    do_reset();

    // static high level across reset release is not an edge
    repeat (3) cyc();
    check("prime_noreq", int'(pinc_bus.pinc_req), 0);

    // falling f10a -> TIME4, request two clocks after the change
    f10a = 1'b0;
    cyc();
    check("t4_lat1", int'(pinc_bus.pinc_req), 0);
    cyc();
    check("t4_req", int'(pinc_bus.pinc_req), 1);
    check("t4_ch",  int'(pinc_bus.pinc_ch),  2);
    pinc_bus.pinc_ack = 1'b1; cyc(); pinc_bus.pinc_ack = 1'b0;

    // simultaneous rise on f10a and f10b: TIME1 first, then TIME3 after a gap
    f10a = 1'b1; f10b = 1'b1;
    cyc(); cyc();
    check("pri_ch0", int'(pinc_bus.pinc_ch), 0);
    pinc_bus.pinc_ack = 1'b1; cyc(); pinc_bus.pinc_ack = 1'b0;
    check("pri_gap", int'(pinc_bus.pinc_req), 0);
    cyc();
    check("pri_req1", int'(pinc_bus.pinc_req), 1);
    check("pri_ch1",  int'(pinc_bus.pinc_ch),  1);
    pinc_bus.pinc_ack = 1'b1; cyc(); pinc_bus.pinc_ack = 1'b0;

    // two TIME1 rises without ack -> one overrun
    tick_en = 1'b0; f10b = 1'b0; cyc();
    tick_en = 1'b1; f10b = 1'b1; cyc();
    tick_en = 1'b0; f10b = 1'b0; cyc();
    tick_en = 1'b1; f10b = 1'b1; cyc();
    check("ovr_flags", int'(ovr_flags), 1);
    check("ovr_count", int'(ovr_count), 1);
    ovr_clr = 1'b1; cyc(); ovr_clr = 1'b0;
    check("clr_flags", int'(ovr_flags), 0);
    check("clr_count", int'(ovr_count), 0);
    check("clr_keep_req", int'(pinc_bus.pinc_req), 1);
    check("clr_keep_ch",  int'(pinc_bus.pinc_ch),  0);
    pinc_bus.pinc_ack = 1'b1; cyc(); pinc_bus.pinc_ack = 1'b0;

    // 20 overruns on TIME3 saturate the counter
    tick_en = 1'b0; f10a = 1'b0; cyc();
    for (int k = 0; k < 21; k++) begin
      tick_en = 1'b1; f10a = 1'b1; cyc();
      tick_en = 1'b0; f10a = 1'b0; cyc();
    end
    check("sat_count", int'(ovr_count), CNTMAX);
    check("sat_flags", int'(ovr_flags), 2);
    tick_en = 1'b1;
    pinc_bus.pinc_ack = 1'b1; cyc(); pinc_bus.pinc_ack = 1'b0;
    ovr_clr = 1'b1; cyc(); ovr_clr = 1'b0;

    // TIME6 channel
    t6_en = 1'b1; f06b = 1'b1;
    cyc(); cyc();
`ifdef TICK_TIME6_EN
    check("t6_req", int'(pinc_bus.pinc_req), 1);
    check("t6_ch",  int'(pinc_bus.pinc_ch),  4);
    pinc_bus.pinc_ack = 1'b1; cyc(); pinc_bus.pinc_ack = 1'b0;
`else
    check("t6_noreq", int'(pinc_bus.pinc_req), 0);
`endif
    f06b = 1'b0; cyc();

    // tick_en low ignores edges
    tick_en = 1'b0; f10a = 1'b1;
    cyc(); cyc();
    check("tick_dis", int'(pinc_bus.pinc_req), 0);
    tick_en = 1'b1;

    // reset while requesting drops pinc_req immediately
    f10a = 1'b0;
    cyc(); cyc();
    check("pre_rst_req", int'(pinc_bus.pinc_req), 1);
    do_reset();
    repeat (3) cyc();
    check("post_rst_req", int'(pinc_bus.pinc_req), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) f10a = ~f10a;
      if ($urandom_range(0, 2) == 0) f10b = ~f10b;
      if ($urandom_range(0, 2) == 0) f06b = ~f06b;
      tick_en           = ($urandom_range(0, 7) != 0);
      t6_en             = ($urandom_range(0, 3) != 0);
      pinc_bus.pinc_ack = ($urandom_range(0, 3) == 0);
      ovr_clr           = ($urandom_range(0, 31) == 0);
      if (n == 1500) do_reset();
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scaler_tick_requester.md
# scaler_tick_requester

Consumes the slow phase outputs of the scaler (F10A, F10B, F06B) and converts their edges into counter-increment (PINC) requests for the TIME1/3/4/5/6 counters. Requests are issued one at a time over a req/ack handshake to the counter-priority logic. Each channel holds one pending request; an edge that arrives while that channel is still pending is recorded as an overrun. The block sits directly downstream of the scaler module and upstream of the counter-increment sequencer.

## Interface
- OVR_CNT_W, 4, width of saturating overrun event counter
- clk  in  1  system clock; the scaler outputs are synchronous to it
- rst_n  in  1  asynchronous, active-low reset
- f10a  in  1  scaler stage-10 A output (level)
- f10b  in  1  scaler stage-10 B output (level)
- f06b  in  1  scaler stage-6 B output (level)
- tick_en  in  1  high: edges may create requests; low: new edges ignored
- t6_en  in  1  TIME6 enable (used only with TICK_TIME6_EN)
- pinc_ack  in  1  counter sequencer accepts current request
- ovr_clr  in  1  one-cycle pulse clearing ovr_flags and ovr_count
- pinc_req  out  1  request valid (registered)
- pinc_ch  out  3  channel index: 0=TIME1, 1=TIME3, 2=TIME4, 3=TIME5, 4=TIME6
- ovr_flags  out  5  sticky per-channel overrun flags
- ovr_count  out  OVR_CNT_W  saturating total overrun count

## Operation
- Channel sources:
  - TIME1: rising f10b.
  - TIME3: rising f10a.
  - TIME4: falling f10a.
  - TIME5: falling f10b.
  - TIME6: rising f06b AND t6_en.
- Edge detection compares each input against its previous registered value.
- Priming: prev registers reset to 0. On the first clk after rst_n deasserts, prev is loaded from the inputs and no edges are detected. A prime flag enforces this.
- pending[ch] is set on a detected edge when tick_en=1.
- Edge on ch while pending[ch]=1 and not being acked that cycle:
  - ovr_flags[ch] is set.
  - ovr_count increments, saturating at all-ones.
  - pending stays 1.
  - If several channels overrun in the same cycle, ovr_count increments by 1 only.
- Edge on ch in the same cycle that ch is acked: pending stays 1, no overrun.
- Arbiter states: IDLE and REQ.
  - IDLE: if any pending bit is set, select the lowest index pending and go to REQ. pinc_req=1 and pinc_ch are registered at that edge.
  - REQ: pinc_ch is held stable. When pinc_ack=1 is sampled, clear pending[pinc_ch], drop pinc_req and return to IDLE.
- pinc_ack while in IDLE is ignored.
- ovr_clr has priority over an overrun occurring in the same cycle: the result is cleared.
- tick_en=0 does not cancel existing pendings; they are still granted.

## Timing
- Reset values:
  - pinc_req=0, pinc_ch=0, ovr_flags=0, ovr_count=0.
  - pending=0, prev=0, prime=1, state IDLE.
- Latency: input changes before posedge N, pending is set at N, pinc_req is high after N+1.
- Ack: pinc_ack high at posedge M gives pinc_req=0 after M. The earliest next pinc_req=1 is after M+1, so there is at least one low cycle between grants.
- Throughput: one grant per 2 clocks maximum.
- Reset mid-request drops pinc_req immediately (asynchronously); the pending request is lost.

## Configuration
- TICK_TIME6_EN defined: channel 4 is active as described above.
- Not defined:
  - t6_en and f06b are ignored.
  - pending[4] is constant 0 and ovr_flags[4] reads 0.
  - pinc_ch never equals 4.
  - Ports are unchanged.

## Structure
- Package agc_tick_pkg:
  - NUM_TICK_CH=5.
  - Channel index constants CH_TIME1..CH_TIME6.
  - Arbiter state enum.
- Sub-module tick_edge_chan, instantiated once per channel. It contains the prev register, the edge select (rise/fall parameter), the pending bit and the overrun flag. It also provides ack-clear and ovr_clr inputs and an ovr_event output.
- The top level holds the prime flag, arbiter, ovr_count and the TIME6 macro gating.

## Test plan
- Reset with f10a=1: no request after reset release. Then drop f10a → TIME4 request: pinc_ch=2, pinc_req high 2 clocks after the change.
- Simultaneous rising f10a and f10b → pinc_ch=0 granted first. After ack, one low cycle, then pinc_ch=1.
- Hold pinc_ack=0 and toggle f10b rising twice → ovr_flags=5'b00001, ovr_count=1. Apply ovr_clr → both 0 and pending is retained.
- 20 overruns on TIME3 with OVR_CNT_W=4 → ovr_count saturates at 15.
- With TICK_TIME6_EN and t6_en=1, rising f06b → pinc_ch=4. Without the macro the same stimulus produces no request.
- tick_en=0 during rising f10a → no request. Assert rst_n low while pinc_req=1 → pinc_req=0 immediately and no request after release.
